// File: rtl/irq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_pkg : shared types and defaults for the interrupt sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int          C_IRQ_PC_W     = 32;
  localparam int          C_IRQ_SRC_W    = 4;
  localparam logic [31:0] C_HANDLER_BASE = 32'h0000_0200;
  localparam logic [31:0] C_VEC_STRIDE   = 32'h0000_0040;

  typedef enum logic [0:0] {
    IRQ_IDLE   = 1'b0,
    IRQ_ACTIVE = 1'b1
  } irq_state_t;

  typedef struct packed {
    logic [C_IRQ_PC_W-1:0]  epc;
    logic [C_IRQ_SRC_W-1:0] src;
  } irq_frame_t;

endpackage
`default_nettype wire

// File: rtl/irq_edge_latch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_edge_latch : rising-edge capture into sticky pending bits
// Rev 1.0
// ---------------------------------------------------------------------------
module irq_edge_latch #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_lvl,
  input  logic [N-1:0] i_clr,
  output logic [N-1:0] o_pending
);

  logic [N-1:0] r_prev;
  logic [N-1:0] r_pending;
  logic [N-1:0] w_rise;

  assign w_rise    = i_lvl & ~r_prev;
  assign o_pending = r_pending;

  // prev resets to ones so a line already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev    <= '1;
      r_pending <= '0;
    end else begin
      r_prev    <= i_lvl;
      r_pending <= (r_pending & ~i_clr) | w_rise;
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_sequencer : prioritised, nesting interrupt take/return PC redirector
// Rev 1.0
// ---------------------------------------------------------------------------
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               NUM_SRC      = 3,
  parameter logic [WIDTH-1:0] HANDLER_BASE = WIDTH'(C_HANDLER_BASE),
  parameter logic [WIDTH-1:0] VEC_STRIDE   = WIDTH'(C_VEC_STRIDE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         irq_in,
  input  logic                       halt,
  input  logic                       stall,
  input  logic                       ex_valid,
  input  logic [WIDTH-1:0]           ex_pc,
  input  logic                       ex_taken,
  input  logic [WIDTH-1:0]           ex_target,
  input  logic                       ex_uret,
  output logic                       flush,
  output logic                       pc_redirect,
  output logic [WIDTH-1:0]           pc_target,
  output logic [NUM_SRC-1:0]         irq_ack,
  output logic                       irq_active,
  output logic [$clog2(NUM_SRC)-1:0] cur_src
);

  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int DEPTH_W = $clog2(NUM_SRC + 1);

  irq_state_t         r_state;
  irq_state_t         w_state_nxt;
  irq_frame_t         r_stack [NUM_SRC];
  logic [DEPTH_W-1:0] r_depth;
  logic [DEPTH_W-1:0] w_top_idx;
  irq_frame_t         w_top;
  irq_frame_t         w_push;
  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_ack;
  logic [SRC_W-1:0]   w_win;
  logic [SRC_W-1:0]   w_cur_src;
  logic               w_any;
  logic               w_take;
  logic               w_ret;
  logic [WIDTH-1:0]   w_epc;

  irq_edge_latch #(
    .N (NUM_SRC)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .i_lvl     (irq_in),
    .i_clr     (w_ack),
    .o_pending (w_pending)
  );

  assign w_top_idx = (r_depth == '0) ? '0 : r_depth - 1'b1;
  assign w_top     = r_stack[w_top_idx];
  assign w_cur_src = (r_depth == '0) ? '0 : SRC_W'(w_top.src);

  // While nested, only strictly higher-priority (lower index) sources may preempt
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_elig[i] = w_pending[i] && ((r_depth == '0) || (i < int'(w_cur_src)));
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any = 1'b1;
        w_win = SRC_W'(i);
      end
    end
  end

  // uret is excluded from take so a coinciding return always pops first
  assign w_take = w_any && ex_valid && !ex_uret && !stall && !halt;
  assign w_ret  = ex_valid && ex_uret && (r_depth != '0) && !stall && !halt;

  assign w_epc      = ex_taken ? ex_target : ex_pc + WIDTH'(4);
  assign w_push.epc = C_IRQ_PC_W'(w_epc);
  assign w_push.src = C_IRQ_SRC_W'(w_win);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_stack[i] <= '0;
      end
      r_depth <= '0;
    end else if (w_take) begin
      r_stack[r_depth] <= w_push;
      r_depth          <= r_depth + 1'b1;
    end else if (w_ret) begin
      r_depth <= r_depth - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IRQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    w_ack       = '0;
    case (r_state)
      IRQ_IDLE: begin
        if (w_take) w_state_nxt = IRQ_ACTIVE;
      end
      IRQ_ACTIVE: begin
        if (w_ret && (r_depth == DEPTH_W'(1))) w_state_nxt = IRQ_IDLE;
      end
      default: w_state_nxt = IRQ_IDLE;
    endcase
    if (w_take) begin
      flush         = 1'b1;
      pc_redirect   = 1'b1;
      pc_target     = HANDLER_BASE + WIDTH'(w_win) * VEC_STRIDE;
      w_ack[w_win]  = 1'b1;
    end else if (w_ret) begin
      flush       = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = WIDTH'(w_top.epc);
    end
  end

  assign irq_ack    = w_ack;
  assign irq_active = (r_state == IRQ_ACTIVE);
  assign cur_src    = w_cur_src;

endmodule
`default_nettype wire

// File: doc/irq_sequencer.md
# irq_sequencer

Prioritised external-interrupt sequencer for the five-stage pipeline CPU.

- Captures rising edges on `NUM_SRC` interrupt lines.
- Picks an interrupt only when the EX stage holds a valid instruction. It then flushes the IF/ID and ID/EX registers and redirects PC to a per-source handler. The return address goes onto a nesting stack.
- A `uret` in EX pops the stack and redirects back.
- It sits beside the branch-redirect logic. Its redirect has priority over branch misprediction recovery.

## Interface
Parameters:
- `WIDTH`, 32, datapath/PC width.
- `NUM_SRC`, 3, interrupt sources. Index 0 is the highest priority.
- `HANDLER_BASE`, 32'h0000_0200, handler address of source 0.
- `VEC_STRIDE`, 32'h40, address step between handlers.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low.
- `irq_in`  in  NUM_SRC  interrupt levels, already synchronised to `clk`.
- `halt`  in  1  CPU halted. Blocks taking interrupts and returning.
- `stall`  in  1  load-use stall this cycle. Blocks taking interrupts and returning.
- `ex_valid`  in  1  EX register holds a real instruction, not a bubble.
- `ex_pc`  in  WIDTH  PC of the EX instruction.
- `ex_taken`  in  1  EX instruction redirects (taken branch, jal, jalr).
- `ex_target`  in  WIDTH  redirect target of the EX instruction.
- `ex_uret`  in  1  EX instruction is `uret`.
- `flush`  out  1  clear IF/ID and ID/EX at the next edge.
- `pc_redirect`  out  1  load `pc_target` into PC at the next edge.
- `pc_target`  out  WIDTH  redirect address.
- `irq_ack`  out  NUM_SRC  one-hot pulse for the source being taken.
- `irq_active`  out  1  nesting depth is not zero.
- `cur_src`  out  $clog2(NUM_SRC)  source at the stack top. 0 when idle.

## Operation
- **Edge capture:**
  - `pending[i]` is set when `irq_in[i]` is 1 and `prev[i]` is 0.
  - `pending[i]` is cleared when source i is taken. If a set and a clear happen in the same cycle, set wins.
  - While `halt` is high, edges are still captured.
- **Eligibility:**
  - When idle, all pending sources are eligible.
  - When active, a pending source is eligible only if its index is below `cur_src` (strict preemption).
  - The winner is the lowest eligible index.
- **Take condition:**
  - Requires: an eligible source exists, `ex_valid`, `!ex_uret`, `!stall`, `!halt`.
  - In that cycle, combinationally: `flush`=1, `pc_redirect`=1, `pc_target` = `HANDLER_BASE + src*VEC_STRIDE`, `irq_ack[src]`=1.
  - At the edge, push {epc, src} and increment the depth.
  - `epc` = `ex_taken ? ex_target : ex_pc+4`. The EX instruction itself completes normally.
- **Return condition:**
  - Requires: `ex_valid && ex_uret && depth!=0 && !stall && !halt`.
  - In that cycle: `flush`=1, `pc_redirect`=1, `pc_target` = top.epc.
  - At the edge, pop. `cur_src` becomes the new top.
  - A `uret` with depth 0 is ignored: no flush, no redirect.
- **Simultaneity:** `uret` in EX takes precedence over a pending interrupt. The interrupt is re-evaluated on the next valid EX cycle against the popped level.
- **Capacity:**
  - Stack depth is `NUM_SRC`. Strict preemption means each source appears at most once, so overflow cannot occur.
  - Depth counter width is `$clog2(NUM_SRC+1)`.
- **States:**
  - IDLE (depth=0) -> ACTIVE on take.
  - ACTIVE -> ACTIVE on nested take or on a pop that leaves depth>0.
  - ACTIVE -> IDLE on the pop at depth=1.

## Timing
- Edge on `irq_in` at edge k sets `pending` at edge k.
  - Earliest take: the cycle after edge k, if EX is valid.
  - Latency from the input edge to `pc_redirect` is one cycle at minimum. It is unbounded while EX holds bubbles, `stall` is high, or `halt` is high.
- `flush`, `pc_redirect`, `pc_target` and `irq_ack` are Mealy outputs, valid within the same cycle as the condition. The handler's first instruction is fetched in the next cycle.
- Reset values:
  - `pending`, stack, depth, `cur_src`: all 0.
  - `prev`: all 1s, so a line held high across reset release does not fire.
  - All outputs: 0.
- Reset asserted mid-handler discards the stack and all pending bits immediately, without waiting for a clock.

## Structure
- Package `irq_pkg`:
  - `irq_frame_t` struct {epc[WIDTH], src}.
  - Default `HANDLER_BASE`/`VEC_STRIDE` constants.
  - State enum {IRQ_IDLE, IRQ_ACTIVE}.
- Sub-module `irq_edge_latch`: holds `prev` and `pending`, with per-bit set/clear. Everything else is in the top.

## Test plan
- **Single interrupt at a straight-line instruction:**
  - Stimulus: pulse `irq_in[1]`; next cycle `ex_valid`=1, `ex_pc`=0x40, `ex_taken`=0.
  - Required: same cycle, `flush`=1, `pc_target`=0x240, `irq_ack`=3'b010.
  - Then: `irq_active`=1, `cur_src`=1. A later `uret` redirects to 0x44.
- **Take with a taken branch in EX:**
  - Stimulus: `ex_taken`=1, `ex_target`=0x100 on the take cycle.
  - Required: epc=0x100. `uret` returns to 0x100, not `ex_pc`+4.
- **Nesting:**
  - Stimulus: in src 2's handler, raise `irq_in[0]`.
  - Required: preempt to 0x200. Two `uret`s return in LIFO order; depth goes 2 -> 1 -> 0.
  - Raising `irq_in[2]` again while src 1 is active stays pending until return.
- **Blocking and simultaneity:**
  - Stimulus: pending interrupt while `ex_valid`=0, `stall`=1 or `halt`=1.
  - Required: no redirect. When `ex_uret` coincides with an eligible source, the pop happens first.
- **Reset:**
  - Stimulus: assert `rst`=0 asynchronously mid-handler, with `irq_in` held high through release.
  - Required: all outputs 0 immediately, and no take after release.
